axi_reflection_lite_slave: RTL and testbench

// AXI4-Lite slave register file that sits directly downstream of the AXI VIP master in the

---
 rtl/axi_reflection_lite_slave_if.sv | 53 +++++
 rtl/axi_reflection_lite_slave.sv | 155 +++++++++++++++
 tb/tb_axi_reflection_lite_slave.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_reflection_lite_slave_if.sv
// AXI4-Lite bus bundle between the VIP master and the reflection register file.
// Pure wiring; no latency.
// Flow control is the usual per-channel valid/ready pairing.
interface axi_reflection_lite_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [2:0]              s_axi_awprot;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [2:0]              s_axi_arprot;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi_reflection_lite_slave.sv
// AXI4-Lite register file with byte strobes; one write and one read outstanding at a time.
// Latency: write commits and raises bvalid one edge after both AW and W are held; rvalid one edge after AR.
// Backpressure: a held channel or a pending bvalid/rvalid drops the matching ready. Optional
// out-of-range SLVERR checking is enabled by defining AXI_REFL_ERR_RESP_EN.
module axi_reflection_lite_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi_reflection_lite_slave_if.slave     s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  r_ar_held;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic             w_awready;
  logic             w_wready;
  logic             w_arready;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_aw_oor;
  logic             w_ar_oor;

  // prot is not modelled and only the index bits of the addresses select a register
  wire w_unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot, r_awaddr, r_araddr};

  // Readies are forced low while reset is asserted so every output reads 0 in reset
  assign w_awready = ARESETN && !r_aw_held && !r_bvalid;
  assign w_wready  = ARESETN && !r_w_held  && !r_bvalid;
  assign w_arready = ARESETN && !r_ar_held && !r_rvalid;
  assign w_aw_hs   = s_axi.s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi.s_axi_wvalid  && w_wready;
  assign w_ar_hs   = s_axi.s_axi_arvalid && w_arready;
  assign w_commit  = r_aw_held && r_w_held;
  assign w_aw_idx  = r_awaddr[ADDR_LSB +: IDX_W];
  assign w_ar_idx  = r_araddr[ADDR_LSB +: IDX_W];

`ifdef AXI_REFL_ERR_RESP_EN
  localparam logic [ADDR_WIDTH:0] REG_SPAN = (ADDR_WIDTH + 1)'(NUM_REGS * 4);
  assign w_aw_oor = {1'b0, r_awaddr} >= REG_SPAN;
  assign w_ar_oor = {1'b0, r_araddr} >= REG_SPAN;
`else
  // Upper address bits are dropped, so every address aliases into the register window
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  assign s_axi.s_axi_awready = w_awready;
  assign s_axi.s_axi_wready  = w_wready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;

  // Write channel bookkeeping: capture AW/W independently, raise B on commit, drop it on bready
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_awaddr  <= s_axi.s_axi_awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= s_axi.s_axi_wdata;
        r_wstrb  <= s_axi.s_axi_wstrb;
        r_w_held <= 1'b1;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axi.s_axi_bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= RESP_OKAY;
      end
    end
  end

  // Register storage: byte-masked update on the commit edge, skipped for out-of-range writes
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && !w_aw_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_wstrb[b]) r_regs[w_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // Read channel: AR held one edge, then return the pre-commit register value until rready
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_ar_held <= 1'b0;
      r_araddr  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_ar_held) begin
      r_ar_held <= 1'b0;
      r_rvalid  <= 1'b1;
      r_rdata   <= w_ar_oor ? '0 : r_regs[w_ar_idx];
      r_rresp   <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_rvalid && s_axi.s_axi_rready) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_araddr  <= s_axi.s_axi_araddr;
      r_ar_held <= 1'b1;
    end
  end

  // Flatten the register array onto the reflection bus
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

endmodule

// File: tb/tb_axi_reflection_lite_slave.sv
// Bench for the AXI4-Lite reflection register file: directed scenarios plus randomized traffic
// compared against a word-array model of the register file.
module tb_axi_reflection_lite_slave;

  logic         clk;
  logic         rstn;
  logic [127:0] reg_out;
  int           tests;
  int           fails;
  logic [31:0]  model [4];

  axi_reflection_lite_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  axi_reflection_lite_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
    .ACLK    (clk),
    .ARESETN (rstn),
    .s_axi   (bus),
    .reg_out (reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [5:0] addr);
`ifdef AXI_REFL_ERR_RESP_EN
    return addr < 6'd16;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int idx_of(input logic [5:0] addr);
    return (int'(addr) / 4) % 4;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (in_range(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx_of(addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit hs_aw, hs_w;
    bit got_b   = 0;
    int cyc     = 0;
    resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      bus.s_axi_awvalid = !aw_done && (cyc >= awd);
      bus.s_axi_awaddr  = addr;
      bus.s_axi_wvalid  = !w_done && (cyc >= wd);
      bus.s_axi_wdata   = data;
      bus.s_axi_wstrb   = strb;
      hs_aw = bus.s_axi_awvalid && bus.s_axi_awready;
      hs_w  = bus.s_axi_wvalid && bus.s_axi_wready;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    cyc = 0;
    while (!got_b && cyc < 20) begin
      if (bus.s_axi_bvalid) begin
        resp = bus.s_axi_bresp;
        got_b = 1;
        bus.s_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    chk("wr_bvalid_seen", got_b, 1'b1);
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    bit got  = 0;
    int cyc  = 0;
    data = 'x;
    resp = 'x;
    while (!done && cyc < 40) begin
      @(negedge clk);
      bus.s_axi_arvalid = 1'b1;
      bus.s_axi_araddr  = addr;
      done = bus.s_axi_arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    chk("rd_accept", done, 1'b1);
    cyc = 0;
    while (!got && cyc < 20) begin
      if (bus.s_axi_rvalid) begin
        data = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
        got = 1;
        bus.s_axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    chk("rd_rvalid_seen", got, 1'b1);
  endtask

  task automatic wr_check(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awd, input int wd);
    logic [1:0] resp;
    do_write(addr, data, strb, awd, wd, resp);
    model_write(addr, data, strb);
    chk({tag, "_bresp"}, resp, in_range(addr) ? 2'b00 : 2'b10);
    chk({tag, "_reg_out"}, reg_out, model_flat());
  endtask

  task automatic rd_check(input string tag, input logic [5:0] addr);
    logic [31:0] data;
    logic [1:0]  resp;
    do_read(addr, data, resp);
    chk({tag, "_rdata"}, data, in_range(addr) ? model[idx_of(addr)] : 32'h0);
    chk({tag, "_rresp"}, resp, in_range(addr) ? 2'b00 : 2'b10);
  endtask

  initial begin
    logic [31:0] old_val;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    rstn = 1'b0;
    bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0; bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_awready", bus.s_axi_awready, 1'b0);
    chk("rst_wready",  bus.s_axi_wready,  1'b0);
    chk("rst_arready", bus.s_axi_arready, 1'b0);
    chk("rst_bvalid",  bus.s_axi_bvalid,  1'b0);
    chk("rst_rvalid",  bus.s_axi_rvalid,  1'b0);
    chk("rst_rdata",   bus.s_axi_rdata,   32'h0);
    chk("rst_reg_out", reg_out, 128'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);

    // T1: four writes with AW/W together, then read back
    for (int i = 0; i < 4; i++) wr_check("t1_wr", 6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) rd_check("t1_rd", 6'(4 * i));
    chk("t1_reg_out_const", reg_out, 128'h00000004_00000003_00000002_00000001);

    // T2: W three cycles ahead of AW
    @(negedge clk);
    bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = 32'hDEADBEEF; bus.s_axi_wstrb = 4'hF;
    chk("t2_wready_first", bus.s_axi_wready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("t2_wready_stalled", bus.s_axi_wready, 1'b0);
      chk("t2_no_bvalid", bus.s_axi_bvalid, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 6'h04;
    chk("t2_awready", bus.s_axi_awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    chk("t2_bvalid_not_yet", bus.s_axi_bvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0;
    chk("t2_bvalid", bus.s_axi_bvalid, 1'b1);
    chk("t2_bresp", bus.s_axi_bresp, 2'b00);
    bus.s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    chk("t2_bvalid_cleared", bus.s_axi_bvalid, 1'b0);
    model_write(6'h04, 32'hDEADBEEF, 4'hF);
    rd_check("t2_rd", 6'h04);

    // T3: partial strobe merge
    wr_check("t3_full", 6'h00, 32'h11223344, 4'hF, 0, 0);
    wr_check("t3_part", 6'h00, 32'hAABBCCDD, 4'b0101, 1, 0);
    chk("t3_reg0_const", reg_out[31:0], 32'h11BB33DD);
    rd_check("t3_rd", 6'h00);

    // T4: B channel stalled five cycles with a second write waiting
    @(negedge clk);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 6'h0C;
    bus.s_axi_wvalid  = 1'b1; bus.s_axi_wdata  = 32'h44; bus.s_axi_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_write(6'h0C, 32'h44, 4'hF);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 6'h08;
    bus.s_axi_wvalid  = 1'b1; bus.s_axi_wdata  = 32'h77;
    for (int k = 0; k < 5; k++) begin
      chk("t4_bvalid_held", bus.s_axi_bvalid, 1'b1);
      chk("t4_readies_low", {bus.s_axi_awready, bus.s_axi_wready}, 2'b00);
      @(posedge clk);
      @(negedge clk);
    end
    chk("t4_second_not_applied", reg_out, model_flat());
    bus.s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    chk("t4_bvalid_cleared", bus.s_axi_bvalid, 1'b0);
    chk("t4_readies_back", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_second_bvalid", bus.s_axi_bvalid, 1'b1);
    bus.s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    model_write(6'h08, 32'h77, 4'hF);
    chk("t4_reg_out", reg_out, model_flat());

    // T5: read sample coinciding with a commit to the same register
    old_val = model[2];
    @(negedge clk);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 6'h08;
    bus.s_axi_wvalid  = 1'b1; bus.s_axi_wdata  = 32'h55; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = 6'h08;
    chk("t5_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b111);
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rvalid", bus.s_axi_rvalid, 1'b1);
    chk("t5_old_value", bus.s_axi_rdata, old_val);
    chk("t5_bvalid", bus.s_axi_bvalid, 1'b1);
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
    chk("t5_rdata_idle_zero", {bus.s_axi_rvalid, bus.s_axi_rdata}, 33'h0);
    model_write(6'h08, 32'h55, 4'hF);
    rd_check("t5_rd_new", 6'h08);
    chk("t5_reg2_const", reg_out[95:64], 32'h55);

    // T6: address just past the register window
    wr_check("t6_wr", 6'h10, 32'h99, 4'hF, 0, 0);
    rd_check("t6_rd", 6'h10);

    // Randomized traffic against the model, including empty strobes and skewed channels
    for (int n = 0; n < 30; n++) begin
      wr_check("rnd_wr", 6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      rd_check("rnd_rd", 6'($urandom_range(0, 63)));
    end

    // T7: reset while AW is held and W never arrives
    @(negedge clk);
    bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 6'h04;
    @(posedge clk);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    chk("t7_readies", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
    chk("t7_b", {bus.s_axi_bvalid, bus.s_axi_bresp}, 3'b000);
    chk("t7_r", {bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata}, 35'h0);
    chk("t7_reg_out", reg_out, 128'h0);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t7_no_bvalid", bus.s_axi_bvalid, 1'b0);
    end
    wr_check("t7_after", 6'h0C, 32'hCAFEF00D, 4'hF, 0, 1);
    rd_check("t7_after", 6'h0C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
